// File: rtl/rr_arb5_onehot.sv
// Five-way round-robin arbiter with a one-hot priority pointer, selectable
// rotation direction and a per-grant burst limit.
module rr_arb5_onehot #(
    parameter int BURST_MAX = 4
) (
    input  logic       clk,
    input  logic       rb,
    input  logic [4:0] req,
    input  logic       dir,
    output logic [4:0] gnt,
    output logic       gnt_vld,
    output logic [2:0] gnt_id
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b01,
        ST_GRANT = 2'b10
    } state_t;

    localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

    state_t     r_state;
    logic [4:0] r_ptr;
    logic [4:0] r_gnt;
    logic       r_gntVld;
    logic [2:0] r_gntId;
    logic [3:0] r_burst;

    logic [4:0] w_nextPtr;
    logic [4:0] w_base;
    logic [2:0] w_baseIdx;
    logic       w_found;
    logic [2:0] w_winId;
    logic [4:0] w_win;
    logic       w_hold;
    logic       w_illegal;

    function automatic logic isOneHot(input logic [4:0] v);
        return (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
    endfunction

    // On a release edge the search starts one past the owner, so the owner
    // itself is reached last and only wins again when nobody else is asking.
    assign w_nextPtr = dir ? {r_gnt[3:0], r_gnt[4]} : {r_gnt[0], r_gnt[4:1]};
    assign w_base    = (r_state == ST_GRANT) ? w_nextPtr : r_ptr;

    always_comb begin
        logic [3:0] pos;
        pos       = 4'd0;
        w_baseIdx = 3'd0;
        w_found   = 1'b0;
        w_winId   = 3'd0;
        for (int i = 0; i < 5; i++) begin
            if (w_base[i]) begin
                w_baseIdx = 3'(i);
            end
        end
        for (int k = 0; k < 5; k++) begin
            if (dir) begin
                pos = {1'b0, w_baseIdx} + 4'(k);
            end else begin
                pos = {1'b0, w_baseIdx} + 4'd5 - 4'(k);
            end
            if (pos >= 4'd5) begin
                pos = pos - 4'd5;
            end
            if (!w_found && req[pos[2:0]]) begin
                w_found = 1'b1;
                w_winId = pos[2:0];
            end
        end
    end

    assign w_win  = w_found ? (5'b00001 << w_winId) : 5'b00000;
    assign w_hold = (|(req & r_gnt)) && (r_burst < BURST_LIM);

    // Any state/pointer/output combination the FSM can never produce on its own.
    assign w_illegal = !((r_state == ST_IDLE) || (r_state == ST_GRANT))
                    || !isOneHot(r_ptr)
                    || ((r_state == ST_IDLE)
                        && ((r_gnt != 5'd0) || r_gntVld || (r_gntId != 3'd0)))
                    || ((r_state == ST_GRANT)
                        && (!isOneHot(r_gnt) || !r_gntVld
                            || (r_gnt != (5'b00001 << r_gntId))
                            || (r_burst == 4'd0) || (r_burst > BURST_LIM)));

    always_ff @(posedge clk or posedge rb) begin
        if (rb) begin
            r_state  <= ST_IDLE;
            r_ptr    <= 5'b00001;
            r_gnt    <= 5'b00000;
            r_gntVld <= 1'b0;
            r_gntId  <= 3'd0;
            r_burst  <= 4'd0;
        end else if (w_illegal) begin
            r_state  <= ST_IDLE;
            r_ptr    <= 5'b00001;
            r_gnt    <= 5'b00000;
            r_gntVld <= 1'b0;
            r_gntId  <= 3'd0;
            r_burst  <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state  <= ST_GRANT;
                        r_gnt    <= w_win;
                        r_gntVld <= 1'b1;
                        r_gntId  <= w_winId;
                        r_burst  <= 4'd1;
                    end
                end
                ST_GRANT: begin
                    if (w_hold) begin
                        r_burst <= r_burst + 4'd1;
                    end else begin
                        r_ptr <= w_nextPtr;
                        if (w_found) begin
                            r_gnt    <= w_win;
                            r_gntVld <= 1'b1;
                            r_gntId  <= w_winId;
                            r_burst  <= 4'd1;
                        end else begin
                            r_state  <= ST_IDLE;
                            r_gnt    <= 5'b00000;
                            r_gntVld <= 1'b0;
                            r_gntId  <= 3'd0;
                            r_burst  <= 4'd0;
                        end
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_ptr    <= 5'b00001;
                    r_gnt    <= 5'b00000;
                    r_gntVld <= 1'b0;
                    r_gntId  <= 3'd0;
                    r_burst  <= 4'd0;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign gnt_vld = r_gntVld;
    assign gnt_id  = r_gntId;

endmodule

// File: tb/tb_rr_arb5_onehot.sv
// Scoreboard bench for rr_arb5_onehot: directed rotation/drop/reset sequences
// followed by randomized traffic checked against an index-based reference model.
module tb_rr_arb5_onehot;

    localparam int BURST_MAX = 4;

    logic       clk;
    logic       rb;
    logic [4:0] req;
    logic       dir;
    logic [4:0] gnt;
    logic       gnt_vld;
    logic [2:0] gnt_id;

    typedef struct {
        logic [4:0] gnt;
        logic       vld;
        logic [2:0] id;
        int         phase;
    } exp_t;

    exp_t expQ[$];
    int   nVectors;
    int   nMiscompares;
    int   curPhase;

    int mOwner;
    int mPtr;
    int mBurst;

    rr_arb5_onehot #(.BURST_MAX(BURST_MAX)) dut (
        .clk     (clk),
        .rb      (rb),
        .req     (req),
        .dir     (dir),
        .gnt     (gnt),
        .gnt_vld (gnt_vld),
        .gnt_id  (gnt_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic string phaseName(input int p);
        case (p)
            0: return "reset";
            1: return "fwd_rot";
            2: return "bwd_rot";
            3: return "sole_req";
            4: return "early_drop";
            5: return "async_rst";
            6: return "dir_in_grant";
            7: return "random";
            default: return "other";
        endcase
    endfunction

    // Reference model: the owner is an index, the pointer an index, rotation is mod-5 arithmetic.
    function automatic int searchFrom(input int start, input logic [4:0] r, input logic d);
        for (int k = 0; k < 5; k++) begin
            int idx;
            idx = d ? (start + k) % 5 : (start - k + 5) % 5;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic modelReset();
        mOwner = -1;
        mPtr   = 0;
        mBurst = 0;
    endtask

    task automatic modelStep(input logic [4:0] r, input logic d);
        if (mOwner < 0) begin
            mOwner = searchFrom(mPtr, r, d);
            mBurst = (mOwner >= 0) ? 1 : 0;
        end else if (r[mOwner] && mBurst < BURST_MAX) begin
            mBurst = mBurst + 1;
        end else begin
            mPtr   = d ? (mOwner + 1) % 5 : (mOwner + 4) % 5;
            mOwner = searchFrom(mPtr, r, d);
            mBurst = (mOwner >= 0) ? 1 : 0;
        end
    endtask

    task automatic pushExp(input logic [4:0] g, input int phase);
        exp_t e;
        e.gnt   = g;
        e.vld   = (g != 5'd0);
        e.id    = 3'd0;
        e.phase = phase;
        for (int i = 0; i < 5; i++) begin
            if (g[i]) e.id = 3'(i);
        end
        expQ.push_back(e);
    endtask

    // Drives one cycle; directed phases push a hand-derived constant, random ones the model.
    task automatic applyStimulus(input logic [4:0] r, input logic d, input bit useConst,
                                 input logic [4:0] constGnt, input int phase);
        logic [4:0] g;
        @(negedge clk);
        req = r;
        dir = d;
        modelStep(r, d);
        g = (mOwner >= 0) ? (5'b00001 << mOwner) : 5'b00000;
        pushExp(useConst ? constGnt : g, phase);
    endtask

    task automatic checkOutput(input string name, input logic [4:0] gotG, input logic gotV,
                               input logic [2:0] gotI, input logic [4:0] expG,
                               input logic expV, input logic [2:0] expI);
        nVectors++;
        if (gotG !== expG || gotV !== expV || gotI !== expI) begin
            nMiscompares++;
            $display("[TB] FAIL %s @%0t: got gnt=%b vld=%b id=%0d, expected gnt=%b vld=%b id=%0d",
                     name, $time, gotG, gotV, gotI, expG, expV, expI);
        end
    endtask

    // Reset asserted between edges; outputs must clear before the next clock edge.
    task automatic asyncReset();
        @(posedge clk);
        #3;
        rb  = 1'b1;
        req = 5'b00000;
        #1;
        checkOutput("async_rst_clear", gnt, gnt_vld, gnt_id, 5'b00000, 1'b0, 3'd0);
        modelReset();
        @(negedge clk);
        pushExp(5'b00000, 0);
        @(negedge clk);
        rb = 1'b0;
        pushExp(5'b00000, 0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(phaseName(e.phase), gnt, gnt_vld, gnt_id, e.gnt, e.vld, e.id);
            end
        end
    end

    initial begin
        logic [4:0] r;
        logic       d;
        logic [4:0] cg;
        nVectors     = 0;
        nMiscompares = 0;
        curPhase     = 0;
        rb  = 1'b1;
        req = 5'b00000;
        dir = 1'b1;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_hold", gnt, gnt_vld, gnt_id, 5'b00000, 1'b0, 3'd0);
        @(negedge clk);
        rb = 1'b0;
        pushExp(5'b00000, 0);

        for (int k = 0; k < 24; k++) begin
            cg = 5'b00001 << ((k / 4) % 5);
            applyStimulus(5'b11111, 1'b1, 1'b1, cg, 1);
        end

        asyncReset();
        for (int k = 0; k < 12; k++) begin
            cg = 5'b00001 << ((5 - (k / 4)) % 5);
            applyStimulus(5'b11111, 1'b0, 1'b1, cg, 2);
        end

        asyncReset();
        for (int k = 0; k < 12; k++) begin
            applyStimulus(5'b00100, 1'b1, 1'b1, 5'b00100, 3);
        end

        asyncReset();
        applyStimulus(5'b00011, 1'b1, 1'b1, 5'b00001, 4);
        applyStimulus(5'b00011, 1'b1, 1'b1, 5'b00001, 4);
        applyStimulus(5'b00010, 1'b1, 1'b1, 5'b00010, 4);
        applyStimulus(5'b00000, 1'b1, 1'b1, 5'b00000, 4);
        applyStimulus(5'b00110, 1'b1, 1'b1, 5'b00100, 4);

        asyncReset();
        applyStimulus(5'b00011, 1'b1, 1'b1, 5'b00001, 5);
        applyStimulus(5'b00011, 1'b1, 1'b1, 5'b00001, 5);
        asyncReset();
        applyStimulus(5'b10000, 1'b1, 1'b1, 5'b10000, 5);
        applyStimulus(5'b10000, 1'b1, 1'b1, 5'b10000, 5);

        asyncReset();
        applyStimulus(5'b11111, 1'b1, 1'b1, 5'b00001, 6);
        applyStimulus(5'b11111, 1'b0, 1'b1, 5'b00001, 6);
        applyStimulus(5'b11111, 1'b0, 1'b1, 5'b00001, 6);
        applyStimulus(5'b11111, 1'b0, 1'b1, 5'b00001, 6);
        applyStimulus(5'b11111, 1'b1, 1'b1, 5'b00010, 6);

        r = 5'b00000;
        d = 1'b1;
        for (int k = 0; k < 1500; k++) begin
            case ($urandom_range(0, 7))
                0, 1: r = 5'($urandom_range(0, 31));
                2:    r = r ^ (5'b00001 << $urandom_range(0, 4));
                3:    r = (gnt_vld && $urandom_range(0, 1) == 1) ? (r & ~gnt) : r;
                default: r = r;
            endcase
            if ($urandom_range(0, 15) == 0) d = ~d;
            if ($urandom_range(0, 199) == 0) begin
                asyncReset();
            end
            applyStimulus(r, d, 1'b0, 5'b00000, 7);
        end

        @(posedge clk);
        #2;
        nVectors++;
        if (expQ.size() != 0) begin
            nMiscompares++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
